// File: rtl/quick_queue_top.sv
// FIFO work-list of (left, right) boundary pairs for the QuickQ sort engine.
// Runtime capacity is array_size, capped at DEPTH; head is read fall-through.
module quick_queue_top #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq,
    input  logic                    deq,
    input  logic [DW-1:0]           data_lt_i,
    input  logic [DW-1:0]           data_rt_i,
    input  logic [7:0]              array_size,
    output logic [DW-1:0]           data_lt_o,
    output logic [DW-1:0]           data_rt_o,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    DEPTH8 = 8'(DEPTH);
    localparam logic [CW-1:0] DEPTHC = CW'(DEPTH);

    logic [DW-1:0] mem_lt_q [DEPTH];
    logic [DW-1:0] mem_rt_q [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] cap;
    logic          push_ok;
    logic          deq_ok;

    always_comb begin
        cap = DEPTHC;
        if (array_size != 8'd0 && array_size <= DEPTH8) begin
            cap = CW'(array_size);
        end
        empty   = (count_q == '0);
        // count may exceed cap after array_size is lowered; still reads as full
        full    = (count_q >= cap);
        deq_ok  = deq && !empty;
        push_ok = enq && (!full || deq_ok);

        head_d  = head_q;
        tail_d  = tail_q;
        if (push_ok) begin
            tail_d = tail_q + AW'(1);
        end
        if (deq_ok) begin
            head_d = head_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(deq_ok);

        data_lt_o = '0;
        data_rt_o = '0;
        if (!empty) begin
            data_lt_o = mem_lt_q[head_q];
            data_rt_o = mem_rt_q[head_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_lt_q[tail_q] <= data_lt_i;
            mem_rt_q[tail_q] <= data_rt_i;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_quick_queue_top.sv
// Scoreboard bench for quick_queue_top: expected pairs are queued on push,
// compared against the fall-through head on pop.
module tb_quick_queue_top;

    localparam int DEPTH = 16;
    localparam int DW    = 32;

    typedef struct {
        logic [31:0] lt;
        logic [31:0] rt;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enq;
    logic          deq;
    logic [DW-1:0] data_lt_i;
    logic [DW-1:0] data_rt_i;
    logic [7:0]    array_size;
    logic [DW-1:0] data_lt_o;
    logic [DW-1:0] data_rt_o;
    logic          empty;
    logic          full;
    logic [4:0]    count;

    int    checks   = 0;
    int    failures = 0;
    pair_t mq[$];

    quick_queue_top #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enq        (enq),
        .deq        (deq),
        .data_lt_i  (data_lt_i),
        .data_rt_i  (data_rt_i),
        .array_size (array_size),
        .data_lt_o  (data_lt_o),
        .data_rt_o  (data_rt_o),
        .empty      (empty),
        .full       (full),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_cap();
        if (array_size == 8'd0 || array_size > 8'(DEPTH)) return DEPTH;
        return int'(array_size);
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(mq.size() >= model_cap()));
        chk({tag, ".lt"}, data_lt_o, (mq.size() != 0) ? mq[0].lt : 32'd0);
        chk({tag, ".rt"}, data_rt_o, (mq.size() != 0) ? mq[0].rt : 32'd0);
    endtask

    // one clock: drive, model acceptance, compare popped head, update model
    task automatic step(input string tag, input logic e, input logic d,
                        input logic [31:0] lt, input logic [31:0] rt);
        bit    full_m;
        bit    pop_m;
        bit    push_m;
        pair_t p;
        enq       = e;
        deq       = d;
        data_lt_i = lt;
        data_rt_i = rt;
        #1;
        full_m = (mq.size() >= model_cap());
        pop_m  = d && (mq.size() != 0);
        push_m = e && (!full_m || pop_m);
        if (pop_m) begin
            chk({tag, ".pop_lt"}, data_lt_o, mq[0].lt);
            chk({tag, ".pop_rt"}, data_rt_o, mq[0].rt);
        end
        @(posedge clk);
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
            p.lt = lt;
            p.rt = rt;
            mq.push_back(p);
        end
        #1;
        chk_state(tag);
        enq = 1'b0;
        deq = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        enq        = 1'b0;
        deq        = 1'b1;
        data_lt_i  = '0;
        data_rt_i  = '0;
        array_size = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) step("deq_empty", 1'b0, 1'b1, '0, '0);

        for (int i = 0; i < 10; i++)
            step("fill_cap3", 1'b1, 1'b0, 32'h49283049, 32'h7);
        chk("fill_cap3.sat_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) step("drain1", 1'b0, 1'b1, '0, '0);

        for (int i = 1; i <= 3; i++)
            step("push123", 1'b1, 1'b0, 32'(i), 32'(i * 10));
        for (int i = 0; i < 4; i++) step("pop123", 1'b0, 1'b1, '0, '0);

        for (int i = 1; i <= 3; i++)
            step("refill", 1'b1, 1'b0, 32'(i), 32'(i * 10));
        step("full_enq_deq", 1'b1, 1'b1, 32'd4, 32'd40);
        chk("full_enq_deq.head", data_lt_o, 32'd2);
        for (int i = 0; i < 3; i++) step("drain234", 1'b0, 1'b1, '0, '0);

        step("empty_enq_deq", 1'b1, 1'b1, 32'hAA, 32'hBB);
        step("empty_enq_deq_pop", 1'b0, 1'b1, '0, '0);

        array_size = 8'd0;
        for (int i = 0; i < 17; i++)
            step("wrap_fill", 1'b1, 1'b0, 32'(100 + i), 32'(200 + i));
        chk("wrap_fill.full16", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++)
            step("wrap_both", 1'b1, 1'b1, 32'(300 + i), 32'(400 + i));
        for (int i = 0; i < 16; i++) step("wrap_drain", 1'b0, 1'b1, '0, '0);

        array_size = 8'd200;
        for (int i = 0; i < 5; i++)
            step("big_cap", 1'b1, 1'b0, 32'(500 + i), 32'(600 + i));
        array_size = 8'd2;
        #1;
        chk("shrink.full", 32'(full), 32'd1);
        step("shrink_enq", 1'b1, 1'b0, 32'hDEAD, 32'hBEEF);
        for (int i = 0; i < 3; i++) step("shrink_pop", 1'b0, 1'b1, '0, '0);
        step("shrink_enq2", 1'b1, 1'b0, 32'hCAFE, 32'hF00D);
        for (int i = 0; i < 2; i++) step("shrink_pop2", 1'b0, 1'b1, '0, '0);

        array_size = 8'd0;
        step("mid_a", 1'b1, 1'b0, 32'd8, 32'd80);
        step("mid_b", 1'b1, 1'b0, 32'd9, 32'd90);
        #3;
        rst = 1'b0;
        mq.delete();
        #1;
        chk_state("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst_push", 1'b1, 1'b0, 32'd5, 32'd50);
        chk("post_rst.head_lt", data_lt_o, 32'd5);
        step("post_rst_pop", 1'b0, 1'b1, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
